fetch_stage: RTL and testbench

Instruction-fetch stage of the ARM pipeline: owns the program counter, drives the byte address into the instruction memory, and captures the returned 32-bit big-endian word into the IF/ID pipeline register. It handles hazard stalls, decode flushes, taken-branch redirects, and detection of a halt word that ends program execution. It sits directly upstream of the instruction memory and downstream of the hazard/branch-resolution logic.

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if.sv | 28 ++
 rtl/fetch_stage_if_id_register.sv | 52 +++++
 rtl/fetch_stage.sv | 82 ++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared constants and state type for the instruction-fetch stage.
// Single-cycle fetch against a combinational instruction memory.
package arm_fetch_pkg;
    localparam int          ADDR_W    = 8;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam int          PC_STEP   = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/branch controls, instruction-memory port and IF/ID outputs.
// master = surrounding pipeline and memory, slave = fetch_stage.
interface fetch_stage_if #(
    parameter int ADDR_W  = arm_fetch_pkg::ADDR_W,
    parameter int INSTR_W = arm_fetch_pkg::INSTR_W
);
    logic               stall;
    logic               flush;
    logic               branch_taken;
    logic [ADDR_W-1:0]  branch_target;
    logic [INSTR_W-1:0] imem_instr;
    logic [ADDR_W-1:0]  imem_addr;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ifid_instr;
    logic [ADDR_W-1:0]  ifid_pc_plus4;
    logic               ifid_valid;
    logic               halted;

    modport master (
        output stall, flush, branch_taken, branch_target, imem_instr,
        input  imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );

    modport slave (
        input  stall, flush, branch_taken, branch_target, imem_instr,
        output imem_addr, pc, ifid_instr, ifid_pc_plus4, ifid_valid, halted
    );
endinterface

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: bubble beats load, otherwise holds; one-cycle capture.
// Holding is the only backpressure; a bubble leaves the captured PC+4 untouched.
module if_id_register #(
    parameter int ADDR_W  = arm_fetch_pkg::ADDR_W,
    parameter int INSTR_W = arm_fetch_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               bubble_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_plus4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_plus4_o,
    output logic               valid_o
);
    import arm_fetch_pkg::*;

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_plus4_q, pc_plus4_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            instr_d = INSTR_W'(NOP_WORD);
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= INSTR_W'(NOP_WORD);
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, captures the addressed word into IF/ID in one cycle.
// Priority branch > stall > flush > fetch; a fetched halt word freezes the stage until reset.
module fetch_stage #(
    parameter int                 ADDR_W    = arm_fetch_pkg::ADDR_W,
    parameter int                 INSTR_W   = arm_fetch_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] HALT_WORD = arm_fetch_pkg::HALT_WORD
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    import arm_fetch_pkg::*;

    fetch_state_t       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic               halted_q;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  target_aligned;
    logic               halt_hit;
    logic               ifid_load;
    logic               ifid_bubble;

    assign pc_plus4       = pc_q + ADDR_W'(PC_STEP);
    assign target_aligned = bus.branch_target & ~ADDR_W'(3);
    assign halt_hit       = (bus.imem_instr == HALT_WORD);

    // A halt word only counts on a plain fetch; on other paths it is wrong-path or not yet consumed.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (state_q == RUN) begin
            if (bus.branch_taken) begin
                ifid_bubble = 1'b1;
            end else if (bus.stall) begin
                ifid_bubble = bus.flush;
            end else if (bus.flush || halt_hit) begin
                ifid_bubble = 1'b1;
            end else begin
                ifid_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else if (state_q == RUN) begin
            if (bus.branch_taken) begin
                pc_q <= target_aligned;
            end else if (!bus.stall) begin
                if (!bus.flush && halt_hit) begin
                    state_q  <= HALTED;
                    halted_q <= 1'b1;
                end else begin
                    pc_q <= pc_plus4;
                end
            end
        end
    end

    if_id_register #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ifid_load),
        .bubble_i   (ifid_bubble),
        .instr_i    (bus.imem_instr),
        .pc_plus4_i (pc_plus4),
        .instr_o    (bus.ifid_instr),
        .pc_plus4_o (bus.ifid_pc_plus4),
        .valid_o    (bus.ifid_valid)
    );

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, corner-case sequences, then random traffic
// against a spec-level model of PC / IF/ID / halt behaviour.
module tb_fetch_stage;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed big-endian instruction memory, read combinationally.
    logic [7:0] mem [256];
    logic [7:0] ma;
    always_comb begin
        ma = bus.imem_addr;
        bus.imem_instr = {mem[ma], mem[ma + 8'd1], mem[ma + 8'd2], mem[ma + 8'd3]};
    end

    function automatic logic [31:0] word_at(int a);
        return {mem[a % 256], mem[(a + 1) % 256], mem[(a + 2) % 256], mem[(a + 3) % 256]};
    endfunction

    task automatic set_word(int a, logic [31:0] w);
        mem[a % 256]       = w[31:24];
        mem[(a + 1) % 256] = w[23:16];
        mem[(a + 2) % 256] = w[15:8];
        mem[(a + 3) % 256] = w[7:0];
    endtask

    // Reference model state.
    int          m_pc;
    logic [31:0] m_instr;
    int          m_pp4;
    bit          m_valid;
    bit          m_halted;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the same edge, sample 1ns after the edge.
    task automatic step(bit r, bit s, bit f, bit b, logic [7:0] t);
        logic [31:0] w;
        reset             = r;
        bus.stall         = s;
        bus.flush         = f;
        bus.branch_taken  = b;
        bus.branch_target = t;
        w = word_at(m_pc);
        if (r) begin
            m_pc = 0; m_instr = 32'h0; m_pp4 = 0; m_valid = 0; m_halted = 0;
        end else if (!m_halted) begin
            if (b) begin
                m_pc = int'(t) / 4 * 4; m_instr = 32'h0; m_valid = 0;
            end else if (s) begin
                if (f) begin m_instr = 32'h0; m_valid = 0; end
            end else if (f) begin
                m_instr = 32'h0; m_valid = 0; m_pc = (m_pc + 4) % 256;
            end else if (w == 32'hFFFF_FFFF) begin
                m_instr = 32'h0; m_valid = 0; m_halted = 1;
            end else begin
                m_instr = w; m_pp4 = (m_pc + 4) % 256; m_valid = 1; m_pc = (m_pc + 4) % 256;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(string tag, logic [7:0] pc, logic [31:0] instr,
                              logic [7:0] pp4, bit v, bit h);
        check({tag, ".pc"},        32'(bus.pc),            32'(pc));
        check({tag, ".imem_addr"}, 32'(bus.imem_addr),     32'(pc));
        check({tag, ".instr"},     bus.ifid_instr,         instr);
        check({tag, ".pc_plus4"},  32'(bus.ifid_pc_plus4), 32'(pp4));
        check({tag, ".valid"},     32'(bus.ifid_valid),    32'(v));
        check({tag, ".halted"},    32'(bus.halted),        32'(h));
    endtask

    typedef struct {
        bit          r, s, f, b;
        logic [7:0]  t;
        logic [7:0]  e_pc;
        logic [31:0] e_instr;
        logic [7:0]  e_pp4;
        bit          e_v, e_h;
    } vec_t;

    vec_t tbl [11];

    initial begin
        checks   = 0;
        failures = 0;
        reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
        bus.branch_taken = 1'b0; bus.branch_target = 8'h00;
        m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0; m_halted = 0;

        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        set_word(8'h00, 32'hE3A0_1001);
        set_word(8'h04, 32'hE3A0_2002);
        set_word(8'h08, 32'hE081_3002);
        set_word(8'h0C, 32'hE283_3001);
        set_word(8'h40, 32'hE591_2000);
        set_word(8'hFC, 32'hEAFF_FFFE);

        //          r  s  f  b  tgt     pc     instr         pp4    v  h
        tbl[0]  = '{1, 0, 0, 0, 8'h00, 8'h00, 32'h0,        8'h00, 0, 0};
        tbl[1]  = '{0, 0, 0, 0, 8'h00, 8'h04, 32'hE3A01001, 8'h04, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 8'h00, 8'h08, 32'hE3A02002, 8'h08, 1, 0};
        tbl[3]  = '{0, 1, 0, 0, 8'h00, 8'h08, 32'hE3A02002, 8'h08, 1, 0};
        tbl[4]  = '{0, 1, 0, 0, 8'h00, 8'h08, 32'hE3A02002, 8'h08, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 8'h00, 8'h0C, 32'hE0813002, 8'h0C, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 8'h00, 8'h10, 32'hE2833001, 8'h10, 1, 0};
        tbl[7]  = '{0, 1, 0, 1, 8'h43, 8'h40, 32'h0,        8'h10, 0, 0};
        tbl[8]  = '{0, 0, 0, 0, 8'h00, 8'h44, 32'hE5912000, 8'h44, 1, 0};
        tbl[9]  = '{0, 0, 0, 1, 8'hFE, 8'hFC, 32'h0,        8'h44, 0, 0};
        tbl[10] = '{0, 0, 0, 0, 8'h00, 8'h00, 32'hEAFFFFFE, 8'h00, 1, 0};

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].f, tbl[i].b, tbl[i].t);
            expect_out($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_instr,
                       tbl[i].e_pp4, tbl[i].e_v, tbl[i].e_h);
        end

        // Halt word presented together with flush is not a halt.
        set_word(8'h0C, 32'hFFFF_FFFF);
        step(1, 0, 0, 0, 8'h00);
        repeat (3) step(0, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        expect_out("halt_flush", 8'h10, 32'h0, 8'h0C, 0, 0);

        // Plain fetch of the halt word, then branch/flush/stall must all be ignored.
        step(1, 0, 0, 0, 8'h00);
        repeat (3) step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        expect_out("halt", 8'h0C, 32'h0, 8'h0C, 0, 1);
        step(0, 0, 0, 1, 8'h40);
        expect_out("halt_br", 8'h0C, 32'h0, 8'h0C, 0, 1);
        step(0, 1, 1, 0, 8'h00);
        expect_out("halt_stall", 8'h0C, 32'h0, 8'h0C, 0, 1);

        // Reset beats everything, in HALTED and under stall.
        step(1, 1, 1, 1, 8'h80);
        expect_out("rst_halted", 8'h00, 32'h0, 8'h00, 0, 0);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        expect_out("pre_rst_stall", 8'h08, 32'hE3A02002, 8'h08, 1, 0);
        step(1, 1, 0, 0, 8'h00);
        expect_out("rst_stall", 8'h00, 32'h0, 8'h00, 0, 0);

        // Random traffic against the model.
        for (int a = 0; a < 256; a += 4)
            set_word(a, ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : 32'($urandom()));
        step(1, 0, 0, 0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
                 8'($urandom_range(0, 255)));
            expect_out($sformatf("rnd%0d", n), 8'(m_pc), m_instr, 8'(m_pp4), m_valid, m_halted);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
